// File: rtl/dbg_snap_pkg.sv
// dbg_snap_pkg: shared types and constants for the debug snapshot streamer.
//   - snap_state_e : controller state encoding
//   - IDX_*        : stream word positions of the snapshot header
//   - snap_words() : number of words in one streamed snapshot
// Optional build macro: DBG_SNAP_CHECKSUM_EN appends an XOR checksum word.
package dbg_snap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_STREAM,
        ST_DONE
    } snap_state_e;

    localparam int IDX_CYCLE = 0;
    localparam int IDX_PC    = 1;
    localparam int IDX_ALU   = 2;
    localparam int IDX_REG0  = 3;

`ifdef DBG_SNAP_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    // Header words, register dump, then the optional checksum word.
    function automatic int snap_words(input int dump_regs);
        return IDX_REG0 + dump_regs + CSUM_WORDS;
    endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// dbg_cycle_counter: free-running 32-bit cycle counter that starts at 1
// out of reset and saturates at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   count - current cycle number
module dbg_cycle_counter (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 32'd1;
        else if (count != 32'hFFFF_FFFF)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/dbg_snapshot_streamer.sv
// dbg_snapshot_streamer: cycle-triggered core snapshot, streamed as words.
// Once armed it waits for cycle_cnt >= trig_cycle, freezes PC / ALU result,
// stalls the core while it walks the register file, then streams
//   cycle, pc, alu, reg[0] .. reg[DUMP_REGS-1] (, checksum)
// over a valid/ready port.
// Optional build macro: DBG_SNAP_CHECKSUM_EN adds a trailing XOR checksum.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   arm, trig_cycle       - arm pulse and trigger cycle number
//   pc_in, alu_out_in     - core state sampled at the trigger edge
//   rf_raddr, rf_rdata    - register-file debug read port
//   core_stall            - freezes the core during register capture
//   out_valid/ready/data/last - snapshot stream
//   busy, done, cycle_cnt - status
module dbg_snapshot_streamer
    import dbg_snap_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DUMP_REGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [31:0]       trig_cycle,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_out_in,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              core_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_cnt
);

    localparam int WORDS  = snap_words(DUMP_REGS);
    localparam int WIDX_W = $clog2(WORDS);

    snap_state_e state, state_nxt;

    logic [DATA_W-1:0]                 snap_cycle, snap_pc, snap_alu;
    logic [DUMP_REGS-1:0][DATA_W-1:0]  regs_q;
    logic [WIDX_W-1:0]                 widx;
    logic [DATA_W-1:0]                 word_mux;
    logic                              trig_hit, cap_last, xfer;

    dbg_cycle_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .count (cycle_cnt)
    );

    assign trig_hit = (cycle_cnt >= trig_cycle);
    assign cap_last = (rf_raddr == ADDR_W'(DUMP_REGS-1));
    assign xfer     = out_valid && out_ready;

    // Stream outputs decode only flops (state, widx, snapshot regs), so they
    // hold still for as long as the consumer withholds ready.
    assign out_valid = (state == ST_STREAM);
    assign out_last  = out_valid && (widx == WIDX_W'(WORDS-1));
    assign out_data  = out_valid ? word_mux : '0;

    always_comb begin
        word_mux = '0;
        if (widx == WIDX_W'(IDX_CYCLE)) word_mux = snap_cycle;
        if (widx == WIDX_W'(IDX_PC))    word_mux = snap_pc;
        if (widx == WIDX_W'(IDX_ALU))   word_mux = snap_alu;
        for (int i = 0; i < DUMP_REGS; i++) begin
            if (widx == WIDX_W'(IDX_REG0 + i)) word_mux = regs_q[i];
        end
`ifdef DBG_SNAP_CHECKSUM_EN
        if (widx == WIDX_W'(WORDS-1)) begin
            word_mux = snap_cycle ^ snap_pc ^ snap_alu;
            for (int i = 0; i < DUMP_REGS; i++) word_mux = word_mux ^ regs_q[i];
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (arm)              state_nxt = ST_ARMED;
            ST_ARMED:   if (trig_hit)         state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (cap_last)         state_nxt = ST_STREAM;
            ST_STREAM:  if (xfer && out_last) state_nxt = ST_DONE;
            ST_DONE:    if (arm)              state_nxt = ST_ARMED;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so core_stall is a
    // clean flop output aligned exactly with the CAPTURE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            core_stall <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_stall <= (state_nxt == ST_CAPTURE);
            busy       <= (state_nxt == ST_ARMED) || (state_nxt == ST_CAPTURE) ||
                          (state_nxt == ST_STREAM);
            done       <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cycle <= '0;
            snap_pc    <= '0;
            snap_alu   <= '0;
            regs_q     <= '0;
            rf_raddr   <= '0;
            widx       <= '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (trig_hit) begin
                        snap_cycle <= DATA_W'(cycle_cnt);
                        snap_pc    <= pc_in;
                        snap_alu   <= alu_out_in;
                        rf_raddr   <= '0;
                        widx       <= '0;
                    end
                end
                ST_CAPTURE: begin
                    // rf_rdata is a combinational read of rf_raddr; the core
                    // is stalled, so it reflects post-trigger contents.
                    for (int i = 0; i < DUMP_REGS; i++) begin
                        if (rf_raddr == ADDR_W'(i)) regs_q[i] <= rf_rdata;
                    end
                    rf_raddr <= cap_last ? '0 : rf_raddr + ADDR_W'(1);
                end
                ST_STREAM: begin
                    if (xfer) widx <= out_last ? '0 : widx + WIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dbg_snapshot_streamer.md
Name: dbg_snapshot_streamer

Overview:
Debug/trace responder inside the MIPS top-level. It counts core cycles from reset and, once armed, triggers at a programmed cycle. On trigger it freezes PC, the EX-stage ALU result and the first DUMP_REGS register-file entries. It then streams the snapshot as 32-bit words over a valid/ready port, so host logic or a bench reads core state over a port instead of peeking hierarchy.

Parameters:
DATA_W, 32, width of every captured and streamed word
ADDR_W, 5, register-file read-address width
DUMP_REGS, 8, number of register-file entries captured, indices 0..DUMP_REGS-1 (1..2**ADDR_W)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse: arm the trigger
trig_cycle  in  32  cycle number to trigger at; sampled every cycle while ARMED
pc_in  in  DATA_W  core program counter
alu_out_in  in  DATA_W  EX-stage ALU result
rf_raddr  out  ADDR_W  register-file debug read address
rf_rdata  in  DATA_W  register-file debug read data (combinational read of rf_raddr)
core_stall  out  1  freeze request to core: no PC update, no register-file writes
out_valid  out  1  stream word valid
out_ready  in  1  stream consumer ready
out_data  out  DATA_W  stream word
out_last  out  1  marks final word of snapshot
busy  out  1  high in ARMED, CAPTURE, STREAM
done  out  1  high in DONE
cycle_cnt  out  32  free-running cycle counter

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cycle_cnt=1, rf_raddr=0, snapshot buffer cleared.
  - core_stall, out_valid, out_last, busy, done=0; out_data=0.
- cycle_cnt increments every clk, including while core_stall=1. It saturates at 32'hFFFF_FFFF; no wrap.
- States: IDLE, ARMED, CAPTURE, STREAM, DONE.
- IDLE: arm=1 -> ARMED.
- ARMED: on the edge where cycle_cnt >= trig_cycle:
  - latch snap_cycle=cycle_cnt, snap_pc=pc_in, snap_alu=alu_out_in;
  - rf_raddr=0; -> CAPTURE.
  - If trig_cycle <= cycle_cnt already when armed, trigger occurs on the first ARMED cycle.
- CAPTURE:
  - core_stall=1 (registered, high exactly while state==CAPTURE).
  - Each cycle store rf_rdata into buf[rf_raddr], then rf_raddr++.
  - After index DUMP_REGS-1 -> STREAM. CAPTURE lasts exactly DUMP_REGS cycles.
  - Register values reflect contents after the trigger edge.
- STREAM:
  - Word order: snap_cycle, snap_pc, snap_alu, buf[0]..buf[DUMP_REGS-1]. WORDS = DUMP_REGS+3.
  - out_valid=1 from the first STREAM cycle.
  - A word transfers on a clk edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last stay stable.
  - out_last=1 only with the final word.
  - Transfer of the last word -> DONE; out_valid drops the next cycle.
- DONE: done=1. arm=1 -> ARMED (re-arm, buffer overwritten at next trigger).
- arm in ARMED, CAPTURE or STREAM is ignored.
- No abort input; only rst_n ends a snapshot early.
- Reset mid-CAPTURE or mid-STREAM: everything returns to reset values immediately; core_stall drops asynchronously.
- Max stream throughput is one word per cycle. No bubble between consecutive words when out_ready stays high.

Optional Feature:
- DBG_SNAP_CHECKSUM_EN defined:
  - one extra word follows buf[DUMP_REGS-1]: XOR of all preceding words;
  - out_last moves to that word; WORDS = DUMP_REGS+4.
- Undefined: no checksum word; WORDS = DUMP_REGS+3.

Decomposition:
- Package dbg_snap_pkg holds:
  - state enum;
  - header index constants IDX_CYCLE=0, IDX_PC=1, IDX_ALU=2, IDX_REG0=3;
  - WORDS computation, including the checksum variant.
- One sub-module, dbg_cycle_counter: saturating 32-bit counter, reset value 1.
- The FSM, buffer and stream mux stay in dbg_snapshot_streamer.

Test Plan:
- Trigger dump: trig_cycle=9, arm at cycle 2, out_ready=1, core preloaded R0=16, R1=0, PC started at 400.
  - CAPTURE starts after the cycle_cnt=9 edge; core_stall high 8 cycles.
  - Stream gives 11 words: 9, snap_pc, snap_alu, 16, 0, ...; out_last on word 11; then done=1.
- Backpressure: out_ready pseudo-random 50%.
  - Exactly 11 transfers, no duplication or loss.
  - out_data/out_last stable on every stalled cycle.
- Late arm: cycle_cnt=20, trig_cycle=3, arm pulse.
  - Trigger on the first ARMED cycle; snap_cycle=21.
- Reset mid-stream: assert rst_n=0 after word 5.
  - out_valid, core_stall, busy drop asynchronously; cycle_cnt=1 after release; state IDLE.
- Arm handling: arm pulse during STREAM is ignored (stream completes, done=1); arm in DONE gives busy=1, done=0.
- Checksum build with DBG_SNAP_CHECKSUM_EN: 12 words; word 12 = XOR of words 1..11; out_last only on word 12.
